// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice: flag bit positions, ALU
// mode codes, branch condition codes, writeback FSM states and mode decode
// helpers used by alu_writeback and alu_cond_eval.
package alu_pkg;

   // Bit positions inside the flag byte / architectural flags register.
   typedef enum logic [2:0] {
      OVERFLOW = 3'd4,
      CARRY    = 3'd5,
      SIGN     = 3'd6,
      ZERO     = 3'd7
   } flag_bit_e;

   // ALU mode codes. Grouping by effect is done by the decode helpers below.
   localparam logic [3:0] MODE_NOP     = 4'd0;
   localparam logic [3:0] MODE_1       = 4'd1;
   localparam logic [3:0] MODE_2       = 4'd2;
   localparam logic [3:0] MODE_3       = 4'd3;
   localparam logic [3:0] MODE_4       = 4'd4;
   localparam logic [3:0] MODE_5       = 4'd5;
   localparam logic [3:0] MODE_6       = 4'd6;
   localparam logic [3:0] MODE_7       = 4'd7;
   localparam logic [3:0] MODE_8       = 4'd8;
   localparam logic [3:0] MODE_9       = 4'd9;
   localparam logic [3:0] MODE_ZONLY   = 4'd10;
   localparam logic [3:0] MODE_11      = 4'd11;
   localparam logic [3:0] MODE_12      = 4'd12;
   localparam logic [3:0] MODE_13      = 4'd13;
   localparam logic [3:0] MODE_14      = 4'd14;
   localparam logic [3:0] MODE_ILLEGAL = 4'd15;

   // Branch condition codes evaluated against the stored flags.
   typedef enum logic [2:0] {
      COND_ALWAYS = 3'd0,
      COND_Z      = 3'd1,
      COND_NZ     = 3'd2,
      COND_C      = 3'd3,
      COND_NC     = 3'd4,
      COND_S      = 3'd5,
      COND_V      = 3'd6,
      COND_LT     = 3'd7
   } cond_e;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wb_state_e;

   // Modes producing a register file write.
   function automatic logic mode_writes(input logic [3:0] mode);
      return (mode == MODE_1) || (mode == MODE_4) || (mode == MODE_5) ||
             ((mode >= MODE_6) && (mode <= MODE_14));
   endfunction

   // Modes replacing all four flags (low nibble cleared).
   function automatic logic mode_sets_all_flags(input logic [3:0] mode);
      return (mode == MODE_2) || (mode == MODE_3) ||
             ((mode >= MODE_6) && (mode <= MODE_14) && (mode != MODE_ZONLY));
   endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Branch condition evaluator: selects one predicate of the stored flags.
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: flags_q (architectural flags), cond_select (condition code) -> cond_true.
module alu_cond_eval
   import alu_pkg::*;
(
   input  logic [7:0] flags_q,
   input  logic [2:0] cond_select,
   output logic       cond_true
);

   // The low nibble of the flags register carries no condition information.
   logic unused_low_flags;
   assign unused_low_flags = ^flags_q[3:0];

   always_comb begin
      cond_true = 1'b0;
      case (cond_e'(cond_select))
         COND_ALWAYS: cond_true = 1'b1;
         COND_Z:      cond_true = flags_q[ZERO];
         COND_NZ:     cond_true = !flags_q[ZERO];
         COND_C:      cond_true = flags_q[CARRY];
         COND_NC:     cond_true = !flags_q[CARRY];
         COND_S:      cond_true = flags_q[SIGN];
         COND_V:      cond_true = flags_q[OVERFLOW];
         COND_LT:     cond_true = flags_q[SIGN] ^ flags_q[OVERFLOW];
         default:     cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures result/flags at issue, holds flags, writes regfile.
// Latency: accept -> wb_valid 1 cycle; flags visible the cycle after accept.
// Backpressure: issue_ready low while a write is pending (or skid full with ALU_WB_SKID_EN).
// Ports: issue_* (ALU op in, valid/ready), alu_result/alu_flags (ALU outputs),
//        wb_* (regfile write port, valid/ready), flags_q/carry_q/cond_true (flag state),
//        illegal_op (pulse on accepted mode 15). Optional macro: ALU_WB_SKID_EN.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int WORD_SIZE     = 8,
   parameter int REG_ADDR_BITS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [3:0]               issue_mode,
   input  logic [REG_ADDR_BITS-1:0] issue_dest,
   input  logic [WORD_SIZE-1:0]     alu_result,
   input  logic [7:0]               alu_flags,
   input  logic [2:0]               cond_select,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [REG_ADDR_BITS-1:0] wb_addr,
   output logic [WORD_SIZE-1:0]     wb_data,
   output logic [7:0]               flags_q,
   output logic                     carry_q,
   output logic                     cond_true,
   output logic                     illegal_op
);

   wb_state_e state_q, state_d;
   logic      accept, acc_write, acc_all_flags, acc_zero_flag, handshake;
   logic      load_issue;

   // Only the upper nibble of the ALU flag byte is architectural.
   logic unused_alu_flag_bits;
   assign unused_alu_flag_bits = ^alu_flags[3:0];

`ifdef ALU_WB_SKID_EN
   logic                     skid_full;
   logic [REG_ADDR_BITS-1:0] skid_addr;
   logic [WORD_SIZE-1:0]     skid_data;
   logic                     load_skid, skid_push, skid_pop;

   assign issue_ready = !skid_full;
`else
   assign issue_ready = (state_q == IDLE);
`endif

   assign accept        = issue_valid && issue_ready;
   assign acc_write     = accept && mode_writes(issue_mode);
   assign acc_all_flags = accept && mode_sets_all_flags(issue_mode);
   assign acc_zero_flag = accept && (issue_mode == MODE_ZONLY);
   assign wb_valid      = (state_q == WRITE);
   assign handshake     = wb_valid && wb_ready;
   assign carry_q       = flags_q[CARRY];

   always_comb begin
      state_d    = state_q;
      load_issue = 1'b0;
`ifdef ALU_WB_SKID_EN
      load_skid  = 1'b0;
      skid_push  = 1'b0;
      skid_pop   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (acc_write) begin
               load_issue = 1'b1;
               state_d    = WRITE;
            end
         end
         WRITE: begin
`ifdef ALU_WB_SKID_EN
            // Output slot drains this cycle: refill it from the skid entry if
            // one is waiting, otherwise straight from a new write so a
            // continuous stream needs no bubble. A write arriving while the
            // output is stalled parks in the skid entry.
            if (handshake) begin
               if (skid_full) begin
                  load_skid = 1'b1;
                  skid_pop  = 1'b1;
               end else if (acc_write) begin
                  load_issue = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (acc_write) begin
               skid_push = 1'b1;
            end
`else
            if (handshake) begin
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         flags_q    <= '0;
         wb_addr    <= '0;
         wb_data    <= '0;
         illegal_op <= 1'b0;
      end else begin
         state_q    <= state_d;
         illegal_op <= accept && (issue_mode == MODE_ILLEGAL);
         // Flags commit at the accept edge so a dependent ADC/SBB issued
         // next cycle already sees the new carry.
         if (acc_all_flags) begin
            flags_q <= {alu_flags[7:4], 4'h0};
         end else if (acc_zero_flag) begin
            flags_q[ZERO] <= alu_flags[ZERO];
         end
         if (load_issue) begin
            wb_addr <= issue_dest;
            wb_data <= alu_result;
`ifdef ALU_WB_SKID_EN
         end else if (load_skid) begin
            wb_addr <= skid_addr;
            wb_data <= skid_data;
`endif
         end
      end
   end

`ifdef ALU_WB_SKID_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_full <= 1'b0;
         skid_addr <= '0;
         skid_data <= '0;
      end else begin
         if (skid_push) begin
            skid_full <= 1'b1;
            skid_addr <= issue_dest;
            skid_data <= alu_result;
         end else if (skid_pop) begin
            skid_full <= 1'b0;
         end
      end
   end
`endif

   alu_cond_eval u_cond_eval (
      .flags_q     (flags_q),
      .cond_select (cond_select),
      .cond_true   (cond_true)
   );

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback with hand-computed expected values.
module tb_alu_writeback;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       issue_valid = 1'b0;
   logic       issue_ready;
   logic [3:0] issue_mode = 4'd0;
   logic [2:0] issue_dest = 3'd0;
   logic [7:0] alu_result = 8'h00;
   logic [7:0] alu_flags = 8'h00;
   logic [2:0] cond_select = 3'd0;
   logic       wb_valid;
   logic       wb_ready = 1'b0;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic [7:0] flags_q;
   logic       carry_q;
   logic       cond_true;
   logic       illegal_op;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_writeback #(.WORD_SIZE(8), .REG_ADDR_BITS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_mode  (issue_mode),
      .issue_dest  (issue_dest),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .cond_select (cond_select),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .flags_q     (flags_q),
      .carry_q     (carry_q),
      .cond_true   (cond_true),
      .illegal_op  (illegal_op)
   );

   // Presents one op at a falling edge once issue_ready is high, holds it
   // across the accepting rising edge, returns 1 time unit after that edge.
   task automatic drive_issue(input logic [3:0] m, input logic [2:0] d,
                              input logic [7:0] r, input logic [7:0] f);
      int n;
      n = 0;
      @(negedge clk);
      while (!issue_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 10) begin
         errors++;
         $display("FAIL issue_ready_timeout: issue_ready=%b required 1", issue_ready);
      end
      issue_valid = 1'b1; issue_mode = m; issue_dest = d; alu_result = r; alu_flags = f;
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      checks++; if (flags_q !== 8'h00) begin errors++; $display("FAIL rst_flags: got %h want 00", flags_q); end
      checks++; if (wb_addr !== 3'd0) begin errors++; $display("FAIL rst_wb_addr: got %0d want 0", wb_addr); end
      checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL rst_wb_data: got %h want 00", wb_data); end
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal_op); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %b want 1", issue_ready); end
      // Reset in the middle of a stalled write.
      wb_ready = 1'b0;
      drive_issue(4'd6, 3'd4, 8'h77, 8'hA0);
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", wb_valid); end
      @(negedge clk); #2; rst = 1'b1; #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_wb_valid: got %b want 0", wb_valid); end
      checks++; if (flags_q !== 8'h00) begin errors++; $display("FAIL midrst_flags: got %h want 00", flags_q); end
      checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL midrst_wb_data: got %h want 00", wb_data); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL midrst_issue_ready: got %b want 1", issue_ready); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_write: got %b want 0", wb_valid); end
   endtask

   task automatic test_full_flags();
      wb_ready = 1'b1;
      drive_issue(4'd6, 3'd3, 8'h00, 8'hA0);
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL full_wb_valid: got %b want 1", wb_valid); end
      checks++; if (wb_addr !== 3'd3) begin errors++; $display("FAIL full_wb_addr: got %0d want 3", wb_addr); end
      checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL full_wb_data: got %h want 00", wb_data); end
      checks++; if (flags_q !== 8'hA0) begin errors++; $display("FAIL full_flags: got %h want a0", flags_q); end
      checks++; if (carry_q !== 1'b1) begin errors++; $display("FAIL full_carry: got %b want 1", carry_q); end
      cond_select = 3'd1; #1;
      checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL full_cond_z: got %b want 1", cond_true); end
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL full_wb_done: got %b want 0", wb_valid); end
   endtask

   task automatic test_flags_only();
      drive_issue(4'd2, 3'd0, 8'hFF, 8'h50);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fonly_no_write: got %b want 0", wb_valid); end
      checks++; if (flags_q !== 8'h50) begin errors++; $display("FAIL fonly_flags: got %h want 50", flags_q); end
      cond_select = 3'd7; #1;
      checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL fonly_cond_lt: got %b want 0", cond_true); end
      cond_select = 3'd5; #1;
      checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL fonly_cond_s: got %b want 1", cond_true); end
      cond_select = 3'd3; #1;
      checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL fonly_cond_c: got %b want 0", cond_true); end
      cond_select = 3'd0; #1;
      checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL fonly_cond_always: got %b want 1", cond_true); end
   endtask

   task automatic test_z_only();
      wb_ready = 1'b1;
      drive_issue(4'd6, 3'd1, 8'h11, 8'hF0);
      checks++; if (flags_q !== 8'hF0) begin errors++; $display("FAIL zonly_pre_flags: got %h want f0", flags_q); end
      drive_issue(4'd10, 3'd5, 8'h06, 8'h00);
      checks++; if (flags_q !== 8'h70) begin errors++; $display("FAIL zonly_flags: got %h want 70", flags_q); end
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL zonly_wb_valid: got %b want 1", wb_valid); end
      checks++; if (wb_data !== 8'h06) begin errors++; $display("FAIL zonly_wb_data: got %h want 06", wb_data); end
      checks++; if (wb_addr !== 3'd5) begin errors++; $display("FAIL zonly_wb_addr: got %0d want 5", wb_addr); end
      cond_select = 3'd1; #1;
      checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL zonly_cond_z: got %b want 0", cond_true); end
      cond_select = 3'd4; #1;
      checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL zonly_cond_nc: got %b want 0", cond_true); end
      cond_select = 3'd6; #1;
      checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL zonly_cond_v: got %b want 1", cond_true); end
      cond_select = 3'd2; #1;
      checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL zonly_cond_nz: got %b want 1", cond_true); end
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL zonly_wb_done: got %b want 0", wb_valid); end
   endtask

   task automatic test_backpressure();
      logic       acc;
      logic       exp_rdy;
      int         n;
      logic [7:0] rec_data [2];
      logic [2:0] rec_addr [2];
      wb_ready = 1'b0;
      drive_issue(4'd1, 3'd2, 8'h5A, 8'hFF);
      // Second write waits behind the stalled first one.
      issue_valid = 1'b1; issue_mode = 4'd4; issue_dest = 3'd6; alu_result = 8'hA5; alu_flags = 8'h00;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
`ifdef ALU_WB_SKID_EN
         exp_rdy = (k == 0);
`else
         exp_rdy = 1'b0;
`endif
         checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_wb_valid[%0d]: got %b want 1", k, wb_valid); end
         checks++; if (wb_addr !== 3'd2) begin errors++; $display("FAIL stall_wb_addr[%0d]: got %0d want 2", k, wb_addr); end
         checks++; if (wb_data !== 8'h5A) begin errors++; $display("FAIL stall_wb_data[%0d]: got %h want 5a", k, wb_data); end
         checks++; if (issue_ready !== exp_rdy) begin errors++; $display("FAIL stall_issue_ready[%0d]: got %b want %b", k, issue_ready, exp_rdy); end
         acc = issue_valid && issue_ready;
         @(posedge clk); #1;
         if (acc) issue_valid = 1'b0;
      end
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         wb_ready = 1'b1;
         if (wb_valid && wb_ready) begin
            if (n < 2) begin
               rec_data[n] = wb_data;
               rec_addr[n] = wb_addr;
            end
            n++;
         end
         acc = issue_valid && issue_ready;
         @(posedge clk); #1;
         if (acc) issue_valid = 1'b0;
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL bp_write_count: got %0d want 2", n); end
      if (n >= 2) begin
         checks++; if (rec_data[0] !== 8'h5A || rec_addr[0] !== 3'd2) begin errors++; $display("FAIL bp_first: got %h@%0d want 5a@2", rec_data[0], rec_addr[0]); end
         checks++; if (rec_data[1] !== 8'hA5 || rec_addr[1] !== 3'd6) begin errors++; $display("FAIL bp_second: got %h@%0d want a5@6", rec_data[1], rec_addr[1]); end
      end
      checks++; if (flags_q !== 8'h70) begin errors++; $display("FAIL bp_flags_kept: got %h want 70", flags_q); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bp_second_accepted: issue still pending, want accepted"); end
   endtask

   task automatic test_illegal();
      wb_ready = 1'b1;
      drive_issue(4'd15, 3'd7, 8'hEE, 8'hFF);
      checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_pulse: got %b want 1", illegal_op); end
      checks++; if (flags_q !== 8'h70) begin errors++; $display("FAIL ill_flags: got %h want 70", flags_q); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ill_no_write: got %b want 0", wb_valid); end
      @(posedge clk); #1;
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_one_cycle: got %b want 0", illegal_op); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ill_no_write_late: got %b want 0", wb_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] res_tab [3];
      int         hs_cyc  [3];
      int         exp_cyc [3];
      logic [7:0] hs_data [3];
      int         idx, n;
      logic       acc;
      res_tab[0] = 8'h11; res_tab[1] = 8'h22; res_tab[2] = 8'h33;
`ifdef ALU_WB_SKID_EN
      exp_cyc[0] = 1; exp_cyc[1] = 2; exp_cyc[2] = 3;
`else
      exp_cyc[0] = 1; exp_cyc[1] = 3; exp_cyc[2] = 5;
`endif
      wb_ready = 1'b1;
      idx = 0; n = 0;
      @(negedge clk);
      issue_valid = 1'b1; issue_mode = 4'd5; issue_dest = 3'd1; alu_result = res_tab[0]; alu_flags = 8'h00;
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge clk);
         if (wb_valid && wb_ready) begin
            if (n < 3) begin
               hs_cyc[n]  = k;
               hs_data[n] = wb_data;
            end
            n++;
         end
         acc = issue_valid && issue_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               issue_dest = 3'(idx + 1);
               alu_result = res_tab[idx];
            end else begin
               issue_valid = 1'b0;
            end
         end
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
      if (n >= 3) begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (hs_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, hs_cyc[i], exp_cyc[i]); end
            checks++; if (hs_data[i] !== res_tab[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, hs_data[i], res_tab[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_flags();
      test_flags_only();
      test_z_only();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
